m68k_bus_responder: RTL and testbench
=====================================

# m68k_bus_responder

Target-side counterpart of the PiStorm bus initiator: sits on the 68000 bus as an address-decoded slave, synchronises incoming bus cycles into the PI_CLK domain, and hands each matching cycle to a host-side request/acknowledge port. It terminates the cycle with DTACK (normal) or BERR (host error or timeout), drives read data onto M68K_D, and releases the bus after AS negates. It lets the CPLD expose Pi-serviced registers to bus masters.

## Interface
Parameters:
- BASE_ADDR, 24'hE90000, decode base (byte address)
- ADDR_MASK, 24'hFF0000, bits compared against BASE_ADDR
- TIMEOUT, 2048, PI_CLK cycles allowed in WAIT_HOST before BERR (must be ≥ 4)

Ports (clock is PI_CLK; reset is asynchronous and active-low, RESET_n):
- PI_CLK  in  1  ~200 MHz block clock
- RESET_n  in  1  asynchronous active-low reset
- M68K_A  in  23  address A[23:1]
- M68K_D  inout  16  data bus; driven only during read response
- M68K_FC  in  3  function code
- M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW  in  1 each  bus strobes
- M68K_DTACK_n  inout  1  driven 0 when asserted, else high-Z
- M68K_BERR_n  inout  1  driven 0 when asserted, else high-Z
- HOST_REQ  out  1  cycle pending for host
- HOST_ADDR  out  23  latched A[23:1]
- HOST_FC  out  3  latched FC
- HOST_RW  out  1  latched RW (1 = read)
- HOST_UDS_n, HOST_LDS_n  out  1 each  latched strobes
- HOST_WDATA  out  16  latched write data
- HOST_ACK  in  1  one-cycle completion pulse
- HOST_ERR  in  1  qualifies HOST_ACK: terminate with BERR
- HOST_RDATA  in  16  read data, valid with HOST_ACK
- HOST_CLR  in  1  clears TIMEOUT_SEEN
- TIMEOUT_SEEN  out  1  sticky: a timeout BERR occurred

## Operation
- All 68K inputs pass through 2-flop synchronisers on PI_CLK; address/data/FC/RW sampled from synchronised copies.
- Cycle match: AS low, (UDS low or LDS low), FC != 3'b111, ({A,1'b0} & ADDR_MASK) == (BASE_ADDR & ADDR_MASK). Strobe condition covers write cycles where UDS/LDS assert one bus clock after AS.
- States:
  - IDLE: on match latch HOST_* fields, go WAIT_HOST, clear timer.
  - WAIT_HOST: HOST_REQ=1; timer increments. HOST_ACK & !HOST_ERR → latch HOST_RDATA, go ACK. HOST_ACK & HOST_ERR → go ERR. Timer == TIMEOUT-1 → set TIMEOUT_SEEN, go ERR. AS high (aborted cycle) → IDLE, ACK that cycle ignored.
  - ACK: DTACK_n=0; if HOST_RW=1 drive M68K_D = latched rdata. AS high → IDLE.
  - ERR: BERR_n=0, no data drive. AS high → IDLE.
- Leaving ACK/ERR releases DTACK, BERR and M68K_D (high-Z) in the same cycle the state changes.
- IDLE does not re-match until AS has been seen high (no double-service of one cycle).
- TIMEOUT_SEEN: set on timeout, cleared by HOST_CLR; simultaneous set and clear → set wins.
- HOST_ACK outside WAIT_HOST is ignored.

## Timing
- Reset values: state IDLE, HOST_REQ 0, HOST_ADDR/HOST_WDATA 0, HOST_FC 3'b111, HOST_RW 1, HOST_UDS_n/HOST_LDS_n 1, TIMEOUT_SEEN 0, DTACK_n/BERR_n/M68K_D high-Z. Reset asserted mid-cycle releases bus immediately (asynchronous), no further REQ.
- Latency: AS+strobe falling edge → HOST_REQ high after 3 PI_CLK rising edges (2 sync + 1 registered).
- HOST_ACK at edge N → DTACK_n low (and data valid) after edge N+1.
- Synchronised AS high at edge M → DTACK/BERR/data released after edge M+1 (≤ 4 PI_CLK ≈ 20 ns after AS negation).
- HOST_* fields stable from HOST_REQ rise until state leaves WAIT_HOST.
- Timer width ≥ clog2(TIMEOUT); no wrap: timeout fires exactly TIMEOUT cycles after entering WAIT_HOST.

## Test plan
- Word read at 0xE90010, FC=5: host ACKs with RDATA=16'hBEEF after 10 cycles → HOST_ADDR=23'h748008, DTACK_n low, M68K_D=BEEF until AS rises, then high-Z within 4 clocks.
- Byte write 0xE90003 data 0x005A, UDS high/LDS delayed one bus clock: → HOST_REQ only after LDS low, HOST_LDS_n=0, HOST_UDS_n=1, HOST_WDATA=005A, M68K_D never driven.
- Address 0xE80000 and FC=7 access at 0xE90000 → no HOST_REQ, DTACK/BERR stay high-Z.
- Host ACK with HOST_ERR=1 → BERR_n low, DTACK high-Z, TIMEOUT_SEEN stays 0.
- No host ACK, TIMEOUT=16 → BERR_n low exactly 16 cycles after HOST_REQ rise, TIMEOUT_SEEN=1; HOST_CLR and timeout on same edge → TIMEOUT_SEEN=1.
- AS negated during WAIT_HOST with HOST_ACK same edge, then RESET_n pulsed during ACK state → return to IDLE with no DTACK; reset releases all bus outputs immediately.

Source files
------------

// File: rtl/m68k_bus_responder_if.sv
// Host-side request/acknowledge port of the 68000 bus responder.
// The responder owns the request fields and the sticky timeout flag;
// the host side answers with ACK/ERR/RDATA and may clear the flag.
interface m68k_bus_responder_if;
  logic        HOST_REQ;
  logic [22:0] HOST_ADDR;
  logic [2:0]  HOST_FC;
  logic        HOST_RW;
  logic        HOST_UDS_n;
  logic        HOST_LDS_n;
  logic [15:0] HOST_WDATA;
  logic        HOST_ACK;
  logic        HOST_ERR;
  logic [15:0] HOST_RDATA;
  logic        HOST_CLR;
  logic        TIMEOUT_SEEN;

  // Responder side: raises requests, reports timeouts.
  modport master (
    output HOST_REQ, HOST_ADDR, HOST_FC, HOST_RW, HOST_UDS_n, HOST_LDS_n,
           HOST_WDATA, TIMEOUT_SEEN,
    input  HOST_ACK, HOST_ERR, HOST_RDATA, HOST_CLR
  );

  // Host side: services requests.
  modport slave (
    input  HOST_REQ, HOST_ADDR, HOST_FC, HOST_RW, HOST_UDS_n, HOST_LDS_n,
           HOST_WDATA, TIMEOUT_SEEN,
    output HOST_ACK, HOST_ERR, HOST_RDATA, HOST_CLR
  );
endinterface

// File: rtl/m68k_bus_responder.sv
// Address-decoded 68000 bus slave. Incoming bus cycles are synchronised
// into PI_CLK, handed to the host port, and terminated with DTACK (read
// data driven on reads) or BERR (host error or timeout). Bus outputs are
// open-drain style: driven low when asserted, high-Z otherwise.
module m68k_bus_responder #(
  parameter logic [23:0] BASE_ADDR = 24'hE90000,
  parameter logic [23:0] ADDR_MASK = 24'hFF0000,
  parameter int          TIMEOUT   = 2048
) (
  input  logic        PI_CLK,
  input  logic        RESET_n,
  input  logic [22:0] M68K_A,
  inout  wire  [15:0] M68K_D,
  input  logic [2:0]  M68K_FC,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  inout  wire         M68K_DTACK_n,
  inout  wire         M68K_BERR_n,
  m68k_bus_responder_if.master host
);

  localparam int          TW        = $clog2(TIMEOUT);
  localparam logic [23:0] MATCH_VAL = BASE_ADDR & ADDR_MASK;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HOST = 2'd1,
    ST_ACK       = 2'd2,
    ST_ERR       = 2'd3
  } state_t;

  // Two-flop synchroniser stages for every 68K input
  logic        r_as_s1,  r_as_s2;
  logic        r_uds_s1, r_uds_s2;
  logic        r_lds_s1, r_lds_s2;
  logic        r_rw_s1,  r_rw_s2;
  logic [22:0] r_a_s1,   r_a_s2;
  logic [2:0]  r_fc_s1,  r_fc_s2;
  logic [15:0] r_d_s1,   r_d_s2;

  // FSM state and registered outputs
  state_t      r_state;
  logic        r_req;
  logic [22:0] r_addr;
  logic [2:0]  r_fc;
  logic        r_rw;
  logic        r_uds_n;
  logic        r_lds_n;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic [TW-1:0] r_timer;
  logic        r_timeout_seen;
  logic        r_dtack_oe;
  logic        r_berr_oe;
  logic        r_d_oe;
  logic        r_armed;

  logic        w_addr_hit;
  logic        w_match;

  // Synchronise the asynchronous 68K bus into PI_CLK. AS resets to the
  // asserted level so a cycle still in progress across reset is never
  // serviced: re-arming needs a genuine AS-high sample.
  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_as_s1  <= 1'b0;
      r_as_s2  <= 1'b0;
      r_uds_s1 <= 1'b1;
      r_uds_s2 <= 1'b1;
      r_lds_s1 <= 1'b1;
      r_lds_s2 <= 1'b1;
      r_rw_s1  <= 1'b1;
      r_rw_s2  <= 1'b1;
      r_a_s1   <= '0;
      r_a_s2   <= '0;
      r_fc_s1  <= 3'b111;
      r_fc_s2  <= 3'b111;
      r_d_s1   <= '0;
      r_d_s2   <= '0;
    end else begin
      r_as_s1  <= M68K_AS_n;
      r_as_s2  <= r_as_s1;
      r_uds_s1 <= M68K_UDS_n;
      r_uds_s2 <= r_uds_s1;
      r_lds_s1 <= M68K_LDS_n;
      r_lds_s2 <= r_lds_s1;
      r_rw_s1  <= M68K_RW;
      r_rw_s2  <= r_rw_s1;
      r_a_s1   <= M68K_A;
      r_a_s2   <= r_a_s1;
      r_fc_s1  <= M68K_FC;
      r_fc_s2  <= r_fc_s1;
      r_d_s1   <= M68K_D;
      r_d_s2   <= r_d_s1;
    end
  end

  // Decode: strobe qualifier lets writes match once the late UDS/LDS arrives;
  // FC=7 (interrupt acknowledge / CPU space) is never ours.
  assign w_addr_hit = (({r_a_s2, 1'b0} & ADDR_MASK) == MATCH_VAL);
  assign w_match    = !r_as_s2 && (!r_uds_s2 || !r_lds_s2) &&
                      (r_fc_s2 != 3'b111) && w_addr_hit && r_armed;

  // Bus-cycle FSM with registered host fields, bus enables and timeout flag
  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state        <= ST_IDLE;
      r_req          <= 1'b0;
      r_addr         <= '0;
      r_fc           <= 3'b111;
      r_rw           <= 1'b1;
      r_uds_n        <= 1'b1;
      r_lds_n        <= 1'b1;
      r_wdata        <= '0;
      r_rdata        <= '0;
      r_timer        <= '0;
      r_timeout_seen <= 1'b0;
      r_dtack_oe     <= 1'b0;
      r_berr_oe      <= 1'b0;
      r_d_oe         <= 1'b0;
      r_armed        <= 1'b0;
    end else begin
      // Any AS-high sample ends the current bus cycle and allows a new match.
      if (r_as_s2) begin
        r_armed <= 1'b1;
      end
      // Clear first; a timeout later in this block overrides it (set wins).
      if (host.HOST_CLR) begin
        r_timeout_seen <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_match) begin
            r_addr  <= r_a_s2;
            r_fc    <= r_fc_s2;
            r_rw    <= r_rw_s2;
            r_uds_n <= r_uds_s2;
            r_lds_n <= r_lds_s2;
            if (!r_rw_s2) begin
              r_wdata <= r_d_s2;
            end
            r_timer <= '0;
            r_req   <= 1'b1;
            r_armed <= 1'b0;
            r_state <= ST_WAIT_HOST;
          end
        end

        ST_WAIT_HOST: begin
          if (r_as_s2) begin
            // Master abandoned the cycle; a late host answer is dropped.
            r_req   <= 1'b0;
            r_state <= ST_IDLE;
          end else if (host.HOST_ACK) begin
            r_req <= 1'b0;
            if (host.HOST_ERR) begin
              r_berr_oe <= 1'b1;
              r_state   <= ST_ERR;
            end else begin
              r_rdata    <= host.HOST_RDATA;
              r_dtack_oe <= 1'b1;
              r_d_oe     <= r_rw;
              r_state    <= ST_ACK;
            end
          end else if (r_timer == TIMER_LAST) begin
            r_timeout_seen <= 1'b1;
            r_req          <= 1'b0;
            r_berr_oe      <= 1'b1;
            r_state        <= ST_ERR;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        ST_ACK: begin
          if (r_as_s2) begin
            r_dtack_oe <= 1'b0;
            r_d_oe     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        ST_ERR: begin
          if (r_as_s2) begin
            r_berr_oe <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_req      <= 1'b0;
          r_dtack_oe <= 1'b0;
          r_berr_oe  <= 1'b0;
          r_d_oe     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Open-drain style bus drivers and read-data driver
  assign M68K_DTACK_n = r_dtack_oe ? 1'b0 : 1'bz;
  assign M68K_BERR_n  = r_berr_oe  ? 1'b0 : 1'bz;
  assign M68K_D       = r_d_oe     ? r_rdata : 16'hzzzz;

  // Host-port outputs
  assign host.HOST_REQ     = r_req;
  assign host.HOST_ADDR    = r_addr;
  assign host.HOST_FC      = r_fc;
  assign host.HOST_RW      = r_rw;
  assign host.HOST_UDS_n   = r_uds_n;
  assign host.HOST_LDS_n   = r_lds_n;
  assign host.HOST_WDATA   = r_wdata;
  assign host.TIMEOUT_SEEN = r_timeout_seen;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder with a request/termination
// scoreboard: stimulus pushes expected host requests and bus terminations,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_m68k_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [22:0] a;
  logic [2:0]  fc;
  logic        as_n, uds_n, lds_n, rw;
  logic        tb_d_oe;
  logic [15:0] tb_d;
  wire  [15:0] d;
  wire         dtack_n;
  wire         berr_n;

  assign d = tb_d_oe ? tb_d : 16'hzzzz;
  pullup (dtack_n);
  pullup (berr_n);
  pullup (d);

  m68k_bus_responder_if host_if ();

  m68k_bus_responder #(.TIMEOUT(16)) dut (
    .PI_CLK       (clk),
    .RESET_n      (rst_n),
    .M68K_A       (a),
    .M68K_D       (d),
    .M68K_FC      (fc),
    .M68K_AS_n    (as_n),
    .M68K_UDS_n   (uds_n),
    .M68K_LDS_n   (lds_n),
    .M68K_RW      (rw),
    .M68K_DTACK_n (dtack_n),
    .M68K_BERR_n  (berr_n),
    .host         (host_if)
  );

  typedef struct {
    logic [22:0] addr;
    logic [2:0]  fc;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [15:0] wdata;
  } req_t;

  typedef struct {
    logic        is_berr;
    logic [15:0] data;
  } term_t;

  req_t  req_q[$];
  term_t term_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each host request and each bus termination
  req_t  mon_r;
  term_t mon_t;
  logic  prev_req   = 1'b0;
  logic  prev_dtack = 1'b1;
  logic  prev_berr  = 1'b1;
  always @(negedge clk) begin
    if (host_if.HOST_REQ === 1'b1 && prev_req !== 1'b1) begin
      if (req_q.size() == 0) begin
        check("unexpected_req_queue", 32'(req_q.size()), 32'd1);
      end else begin
        mon_r = req_q.pop_front();
        check("req_addr", {9'd0, host_if.HOST_ADDR}, {9'd0, mon_r.addr});
        check("req_fc", {29'd0, host_if.HOST_FC}, {29'd0, mon_r.fc});
        check("req_rw", {31'd0, host_if.HOST_RW}, {31'd0, mon_r.rw});
        check("req_uds_n", {31'd0, host_if.HOST_UDS_n}, {31'd0, mon_r.uds_n});
        check("req_lds_n", {31'd0, host_if.HOST_LDS_n}, {31'd0, mon_r.lds_n});
        if (!mon_r.rw) check("req_wdata", {16'd0, host_if.HOST_WDATA}, {16'd0, mon_r.wdata});
        $display("req  addr=%06h fc=%0d rw=%0b uds_n=%0b lds_n=%0b wdata=%04h",
                 host_if.HOST_ADDR, host_if.HOST_FC, host_if.HOST_RW,
                 host_if.HOST_UDS_n, host_if.HOST_LDS_n, host_if.HOST_WDATA);
      end
    end
    if ((dtack_n === 1'b0 && prev_dtack !== 1'b0) || (berr_n === 1'b0 && prev_berr !== 1'b0)) begin
      if (term_q.size() == 0) begin
        check("unexpected_term_queue", 32'(term_q.size()), 32'd1);
      end else begin
        mon_t = term_q.pop_front();
        check("term_berr_n", {31'd0, berr_n}, {31'd0, !mon_t.is_berr});
        check("term_dtack_n", {31'd0, dtack_n}, {31'd0, mon_t.is_berr});
        check("term_data", {16'd0, d}, {16'd0, mon_t.data});
        $display("term dtack_n=%0b berr_n=%0b d=%04h", dtack_n, berr_n, d);
      end
    end
    prev_req   <= host_if.HOST_REQ;
    prev_dtack <= dtack_n;
    prev_berr  <= berr_n;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start a bus cycle just after a rising edge
  task automatic start_cycle(input logic [22:0] addr, input logic [2:0] f,
                             input logic r, input logic u, input logic l);
    @(posedge clk);
    #1;
    a = addr; fc = f; rw = r; uds_n = u; lds_n = l; as_n = 1'b0;
  endtask

  // Count rising edges until HOST_REQ is seen (returns at a falling edge)
  task automatic wait_req(output int n);
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (host_if.HOST_REQ === 1'b1) break;
    end
  endtask

  // Host answer: asserted after the next edge, sampled on the one after
  task automatic host_ack(input logic err, input logic [15:0] rdata);
    @(posedge clk);
    #1;
    host_if.HOST_ACK = 1'b1; host_if.HOST_ERR = err; host_if.HOST_RDATA = rdata;
    @(posedge clk);
    #1;
    host_if.HOST_ACK = 1'b0; host_if.HOST_ERR = 1'b0;
  endtask

  // Negate AS/strobes and count edges until every bus output is released
  task automatic release_bus(output int n);
    @(posedge clk);
    #1;
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; tb_d_oe = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (dtack_n === 1'b1 && berr_n === 1'b1 && d === 16'hFFFF) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int n;
  int k;
  logic found;

  initial begin
    rst_n = 1'b0; a = '0; fc = 3'd0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    rw = 1'b1; tb_d_oe = 1'b0; tb_d = '0;
    host_if.HOST_ACK = 1'b0; host_if.HOST_ERR = 1'b0;
    host_if.HOST_RDATA = '0; host_if.HOST_CLR = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, host_if.HOST_REQ}, 32'd0);
    check("rst_addr", {9'd0, host_if.HOST_ADDR}, 32'd0);
    check("rst_fc", {29'd0, host_if.HOST_FC}, 32'd7);
    check("rst_rw", {31'd0, host_if.HOST_RW}, 32'd1);
    check("rst_uds_n", {31'd0, host_if.HOST_UDS_n}, 32'd1);
    check("rst_lds_n", {31'd0, host_if.HOST_LDS_n}, 32'd1);
    check("rst_wdata", {16'd0, host_if.HOST_WDATA}, 32'd0);
    check("rst_timeout_seen", {31'd0, host_if.TIMEOUT_SEEN}, 32'd0);
    check("rst_dtack_n", {31'd0, dtack_n}, 32'd1);
    check("rst_berr_n", {31'd0, berr_n}, 32'd1);
    check("rst_d", {16'd0, d}, 32'h0000FFFF);
    $display("reset checked");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(4);

    // Word read at 0xE90010, FC=5, host answers BEEF after 10 cycles
    req_q.push_back('{addr: 23'h748008, fc: 3'd5, rw: 1'b1, uds_n: 1'b0, lds_n: 1'b0, wdata: 16'h0000});
    start_cycle(23'h748008, 3'd5, 1'b1, 1'b0, 1'b0);
    wait_req(n);
    check("read_req_latency", n, 3);
    repeat (9) @(posedge clk);
    term_q.push_back('{is_berr: 1'b0, data: 16'hBEEF});
    host_ack(1'b0, 16'hBEEF);
    @(negedge clk);
    check("read_dtack_latency", {31'd0, dtack_n}, 32'd0);
    tick(5);
    @(negedge clk);
    check("read_d_held", {16'd0, d}, 32'h0000BEEF);
    check("read_req_dropped", {31'd0, host_if.HOST_REQ}, 32'd0);
    release_bus(n);
    check("read_release_edges", n, 3);
    $display("read 0xE90010 done, release after %0d edges", n);

    // Byte write 0xE90003, LDS arrives one bus clock after AS
    tick(2);
    req_q.push_back('{addr: 23'h748001, fc: 3'd1, rw: 1'b0, uds_n: 1'b1, lds_n: 1'b0, wdata: 16'h005A});
    tb_d = 16'h005A; tb_d_oe = 1'b1;
    start_cycle(23'h748001, 3'd1, 1'b0, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    check("write_no_req_before_lds", {31'd0, host_if.HOST_REQ}, 32'd0);
    @(posedge clk);
    #1 lds_n = 1'b0;
    wait_req(n);
    check("write_req_latency", n, 3);
    tb_d_oe = 1'b0;
    term_q.push_back('{is_berr: 1'b0, data: 16'hFFFF});
    host_ack(1'b0, 16'h1234);
    @(negedge clk);
    check("write_dtack", {31'd0, dtack_n}, 32'd0);
    check("write_d_not_driven", {16'd0, d}, 32'h0000FFFF);
    release_bus(n);
    check("write_release_edges", n, 3);
    $display("write 0xE90003 done");

    // Non-matching address 0xE80000
    tick(2);
    start_cycle(23'h740000, 3'd5, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("miss_addr_req", {31'd0, host_if.HOST_REQ}, 32'd0);
    check("miss_addr_dtack_n", {31'd0, dtack_n}, 32'd1);
    check("miss_addr_berr_n", {31'd0, berr_n}, 32'd1);
    release_bus(n);
    $display("miss 0xE80000 done");

    // FC=7 at a matching address
    tick(2);
    start_cycle(23'h748000, 3'd7, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("miss_fc7_req", {31'd0, host_if.HOST_REQ}, 32'd0);
    check("miss_fc7_dtack_n", {31'd0, dtack_n}, 32'd1);
    check("miss_fc7_berr_n", {31'd0, berr_n}, 32'd1);
    release_bus(n);
    $display("miss fc=7 done");

    // Host error termination
    tick(2);
    req_q.push_back('{addr: 23'h748010, fc: 3'd6, rw: 1'b1, uds_n: 1'b0, lds_n: 1'b0, wdata: 16'h0000});
    start_cycle(23'h748010, 3'd6, 1'b1, 1'b0, 1'b0);
    wait_req(n);
    check("err_req_latency", n, 3);
    repeat (2) @(posedge clk);
    term_q.push_back('{is_berr: 1'b1, data: 16'hFFFF});
    host_ack(1'b1, 16'h7777);
    @(negedge clk);
    check("err_berr_n", {31'd0, berr_n}, 32'd0);
    check("err_timeout_seen", {31'd0, host_if.TIMEOUT_SEEN}, 32'd0);
    release_bus(n);
    check("err_release_edges", n, 3);
    $display("host error done");

    // Timeout with HOST_CLR on the same edge
    tick(2);
    req_q.push_back('{addr: 23'h748080, fc: 3'd5, rw: 1'b1, uds_n: 1'b0, lds_n: 1'b0, wdata: 16'h0000});
    start_cycle(23'h748080, 3'd5, 1'b1, 1'b0, 1'b0);
    wait_req(n);
    check("tmo_req_latency", n, 3);
    term_q.push_back('{is_berr: 1'b1, data: 16'hFFFF});
    k = 0;
    found = 1'b0;
    while (k < 40 && !found) begin
      @(posedge clk);
      k++;
      #1 host_if.HOST_CLR = (k == 15);
      @(negedge clk);
      if (berr_n === 1'b0) found = 1'b1;
    end
    check("tmo_cycles", k, 16);
    check("tmo_seen_set_wins", {31'd0, host_if.TIMEOUT_SEEN}, 32'd1);
    release_bus(n);
    check("tmo_release_edges", n, 3);
    check("tmo_seen_sticky", {31'd0, host_if.TIMEOUT_SEEN}, 32'd1);
    @(posedge clk);
    #1 host_if.HOST_CLR = 1'b1;
    @(posedge clk);
    #1 host_if.HOST_CLR = 1'b0;
    @(negedge clk);
    check("tmo_seen_cleared", {31'd0, host_if.TIMEOUT_SEEN}, 32'd0);
    $display("timeout done after %0d cycles", k);

    // Abort: synchronised AS high reaches the FSM on the same edge as ACK
    tick(2);
    req_q.push_back('{addr: 23'h748020, fc: 3'd5, rw: 1'b1, uds_n: 1'b0, lds_n: 1'b0, wdata: 16'h0000});
    start_cycle(23'h748020, 3'd5, 1'b1, 1'b0, 1'b0);
    wait_req(n);
    check("abort_req_latency", n, 3);
    tick(3);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    host_if.HOST_ACK = 1'b1; host_if.HOST_RDATA = 16'hDEAD;
    @(posedge clk);
    #1 host_if.HOST_ACK = 1'b0;
    @(negedge clk);
    check("abort_req_dropped", {31'd0, host_if.HOST_REQ}, 32'd0);
    check("abort_no_dtack", {31'd0, dtack_n}, 32'd1);
    tick(5);
    @(negedge clk);
    check("abort_no_dtack_later", {31'd0, dtack_n}, 32'd1);
    check("abort_d_released", {16'd0, d}, 32'h0000FFFF);
    $display("abort done");

    // Reset pulsed while in ACK with AS still low
    tick(2);
    req_q.push_back('{addr: 23'h748028, fc: 3'd5, rw: 1'b1, uds_n: 1'b0, lds_n: 1'b0, wdata: 16'h0000});
    start_cycle(23'h748028, 3'd5, 1'b1, 1'b0, 1'b0);
    wait_req(n);
    check("rstack_req_latency", n, 3);
    term_q.push_back('{is_berr: 1'b0, data: 16'hCAFE});
    host_ack(1'b0, 16'hCAFE);
    @(negedge clk);
    check("rstack_dtack", {31'd0, dtack_n}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rstack_dtack_released", {31'd0, dtack_n}, 32'd1);
    check("rstack_d_released", {16'd0, d}, 32'h0000FFFF);
    check("rstack_req_low", {31'd0, host_if.HOST_REQ}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rstack_no_new_req", {31'd0, host_if.HOST_REQ}, 32'd0);
    check("rstack_no_dtack", {31'd0, dtack_n}, 32'd1);
    @(posedge clk);
    #1;
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    tick(5);
    $display("reset during ack done");

    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    check("term_queue_drained", 32'(term_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
